// File: rtl/alu_seq.sv
`default_nettype none
//============================================================================
// Module      : alu_seq
// Description : Handshaked ALU; one-cycle add/sub/logic/compare and an
//               optional WIDTH-cycle shift-add multiplier (ALU_SEQ_MUL_EN).
// Revision    : 1.0 - initial release
//============================================================================
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             err
);

    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_hold     = 2'd2;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [1:0] c_mul_busy = 2'd1;
    localparam int         CW         = $clog2(WIDTH);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);
    localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);
`endif

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [1:0]       w_accept_state;
    logic             w_accept;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic             w_err;

    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_zero;
    logic             r_carry;
    logic             r_overflow;
    logic             r_err;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_accept_state = (op == 3'd2) ? c_mul_busy : c_hold;
    assign w_acc_next     = r_b_sh[0] ? (r_acc + r_a_sh) : r_acc;
`else
    assign w_accept_state = c_hold;
`endif

    assign w_accept = in_valid && in_ready;

    // Single-cycle datapath; also covers op=2 when the multiplier is absent
    always_comb begin
        w_sum   = {1'b0, data_1} + {1'b0, data_2};
        w_diff  = data_1 - data_2;
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (op)
            3'd0: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (data_1[WIDTH-1] == data_2[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != data_1[WIDTH-1]);
            end
            3'd1: begin
                w_res   = w_diff;
                w_carry = data_1 < data_2;
                w_ovf   = (data_1[WIDTH-1] != data_2[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != data_1[WIDTH-1]);
            end
            3'd2: begin
`ifndef ALU_SEQ_MUL_EN
                w_err = 1'b1;
`endif
            end
            3'd3: w_res = ~(data_1 & data_2);
            3'd4: w_res = data_1 & data_2;
            3'd5: w_res = data_1 | data_2;
            3'd6: w_res = data_1 ^ data_2;
            3'd7: w_res = {{(WIDTH-1){1'b0}}, ($signed(data_1) < $signed(data_2))};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (in_valid) w_next_state = w_accept_state;
            end
            c_hold: begin
                if (out_ready) w_next_state = in_valid ? w_accept_state : c_idle;
            end
`ifdef ALU_SEQ_MUL_EN
            c_mul_busy: begin
                if (r_cnt == c_cnt_last) w_next_state = c_hold;
            end
`endif
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_idle) || ((r_state == c_hold) && out_ready);
        out_valid = (r_state == c_hold);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_err       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_acc       <= '0;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_cnt       <= '0;
`endif
        end else if (w_accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (op == 3'd2) begin
                r_a_sh <= {{WIDTH{1'b0}}, data_1};
                r_b_sh <= data_2;
                r_acc  <= '0;
                r_cnt  <= '0;
            end else
`endif
            begin
                r_result    <= w_res;
                r_result_hi <= '0;
                r_zero      <= (w_res == '0);
                r_carry     <= w_carry;
                r_overflow  <= w_ovf;
                r_err       <= w_err;
            end
        end
`ifdef ALU_SEQ_MUL_EN
        // Final iteration writes the product straight into the result registers
        else if (r_state == c_mul_busy) begin
            r_acc  <= w_acc_next;
            r_a_sh <= r_a_sh << 1;
            r_b_sh <= r_b_sh >> 1;
            r_cnt  <= r_cnt + c_cnt_one;
            if (r_cnt == c_cnt_last) begin
                r_result    <= w_acc_next[WIDTH-1:0];
                r_result_hi <= w_acc_next[2*WIDTH-1:WIDTH];
                r_zero      <= (w_acc_next[WIDTH-1:0] == '0);
                r_carry     <= 1'b0;
                r_overflow  <= (w_acc_next[2*WIDTH-1:WIDTH] != '0);
                r_err       <= 1'b0;
            end
        end
`endif
    end

    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
//============================================================================
// Module      : tb_alu_seq
// Description : Directed and randomized scoreboard bench for alu_seq.
// Revision    : 1.0 - initial release
//============================================================================
module tb_alu_seq;

    localparam int W = 32;
`ifdef ALU_SEQ_MUL_EN
    localparam int MUL_LAT = W + 1;
`else
    localparam int MUL_LAT = 1;
`endif
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         zero;
        logic         carry;
        logic         ovf;
        logic         err;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] data_1 = '0;
    logic [W-1:0] data_2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         carry;
    logic         overflow;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .data_1    (data_1),
        .data_2    (data_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [2*W+3:0] got, input logic [2*W+3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour from plain integer arithmetic
    function automatic res_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        longint          sa;
        longint          sb;
        longint          ss;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned full;
        r  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd0: begin
                full    = ua + ub;
                r.lo    = full[31:0];
                r.carry = full > 64'hFFFF_FFFF;
                ss      = sa + sb;
                r.ovf   = (ss > MAXS) || (ss < MINS);
            end
            3'd1: begin
                r.lo    = a - b;
                r.carry = a < b;
                ss      = sa - sb;
                r.ovf   = (ss > MAXS) || (ss < MINS);
            end
            3'd2: begin
`ifdef ALU_SEQ_MUL_EN
                full  = ua * ub;
                r.lo  = full[31:0];
                r.hi  = full[63:32];
                r.ovf = r.hi != 0;
`else
                r.err = 1'b1;
`endif
            end
            3'd3: r.lo = ~(a & b);
            3'd4: r.lo = a & b;
            3'd5: r.lo = a | b;
            3'd6: r.lo = a ^ b;
            3'd7: r.lo = (sa < sb) ? 32'd1 : 32'd0;
        endcase
        r.zero = (r.lo == 0);
        return r;
    endfunction

    function automatic res_t observed();
        return {result_hi, result, zero, carry, overflow, err};
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Offer an op and return #1 after the edge that accepted it
    task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        @(negedge clk);
        op = o; data_1 = a; data_2 = b; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (!in_ready) check_eq("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_1   = $urandom;
        data_2   = $urandom;
        op       = 3'($urandom_range(0, 7));
    endtask

    // Edges from accept until the edge at which a consumer sees out_valid
    task automatic wait_out(output int lat, output int busy_ready);
        lat        = 1;
        busy_ready = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ready++;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_lat);
        int lat;
        int busy_ready;
        send(o, a, b);
        wait_out(lat, busy_ready);
        check_eq({tag, "_latency"}, (2*W+4)'(lat), (2*W+4)'(exp_lat));
        check_eq({tag, "_result"}, observed(), model(o, a, b));
        if (exp_lat > 1) check_eq({tag, "_busy_in_ready"}, (2*W+4)'(busy_ready), 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, "_drained"}, (2*W+4)'(out_valid), 0);
    endtask

    initial begin
        res_t exp_r;
        res_t q[$];
        int   unstable;
        int   n;
        logic acc_last;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_out_valid", (2*W+4)'(out_valid), 0);
        check_eq("reset_in_ready", (2*W+4)'(in_ready), 1);
        check_eq("reset_outputs", observed(), '0);
        @(negedge clk);
        rst = 1'b1;

        run_op("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'd1, 1);
        run_op("sub_ovf", 3'd1, 32'h8000_0000, 32'd1, 1);
        run_op("slt_neg", 3'd7, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("sub_borrow", 3'd1, 32'd3, 32'd5, 1);
        run_op("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'd1, 1);
`ifdef ALU_SEQ_MUL_EN
        run_op("mul_hi", 3'd2, 32'h0001_0000, 32'h0001_0000, MUL_LAT);
        run_op("mul_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
`else
        run_op("mul_absent", 3'd2, 32'd3, 32'd4, MUL_LAT);
`endif
        run_op("add_small", 3'd0, 32'd3, 32'd4, 1);

        // Backpressure then back-to-back accept on the drain edge
        send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        exp_r    = model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            if (observed() !== exp_r || !out_valid || in_ready) unstable++;
            @(posedge clk); #1;
        end
        check_eq("bp_stable", (2*W+4)'(unstable), 0);
        check_eq("bp_nand", observed(), exp_r);
        @(negedge clk);
        in_valid = 1'b1; op = 3'd6; data_1 = 32'hF0; data_2 = 32'hFF; out_ready = 1'b1;
        #1;
        check_eq("b2b_in_ready", (2*W+4)'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check_eq("b2b_out_valid", (2*W+4)'(out_valid), 1);
        check_eq("b2b_xor", observed(), model(3'd6, 32'hF0, 32'hFF));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset while an op is in flight
`ifdef ALU_SEQ_MUL_EN
        send(3'd2, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(posedge clk);
`else
        send(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check_eq("abort_out_valid", (2*W+4)'(out_valid), 0);
        check_eq("abort_in_ready", (2*W+4)'(in_ready), 1);
        check_eq("abort_outputs", observed(), '0);
        run_op("post_reset_add", 3'd0, 32'd2, 32'd3, 1);

        // Random stream against a result queue
        acc_last = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            if (!in_valid || acc_last) begin
                in_valid = ($urandom_range(0, 3) != 0);
                op       = 3'($urandom_range(0, 7));
                data_1   = rnd_operand();
                data_2   = rnd_operand();
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid) begin
                if (q.size() == 0) check_eq("stream_spurious", 1, 0);
                else begin
                    check_eq("stream", observed(), q[0]);
                    if (out_ready) void'(q.pop_front());
                end
            end
            acc_last = in_valid && in_ready;
            if (acc_last) q.push_back(model(op, data_1, data_2));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            #1;
            if (out_valid) begin
                check_eq("stream_drain", observed(), q[0]);
                void'(q.pop_front());
            end
            @(negedge clk);
            n++;
        end
        check_eq("stream_empty", (2*W+4)'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
